// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetches the word at the core pc over a req/gnt/rvalid imem port; timeouts and misaligned pcs yield NOP.
// Define FETCH_REUSE_EN to add a 1-entry reuse buffer that skips memory when the same pc is fetched again.
module inst_fetch_unit #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        fetch_err_o,
    output logic [31:0] fetch_cnt_o
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d, inst_q, inst_d, cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic          misaligned, expired, hit;
    logic [31:0]   hit_inst;
    assign misaligned = addr_q[1:0] != 2'b00;
    assign expired    = timer_q == TW'(TIMEOUT - 1);
`ifdef FETCH_REUSE_EN
    logic        tag_v_q;
    logic [31:0] tag_pc_q, tag_inst_q;
    assign hit      = tag_v_q && addr_q == tag_pc_q;
    assign hit_inst = tag_inst_q;
    // Refilled by every successful read; dropped whenever a fetch falls back to NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_q    <= 1'b0;
            tag_pc_q   <= '0;
            tag_inst_q <= NOP_INST;
        end else if (state_q == S_WAIT && imem_rvalid_i) begin
            tag_v_q    <= 1'b1;
            tag_pc_q   <= addr_q;
            tag_inst_q <= imem_rdata_i;
        end else if ((state_q == S_REQ && misaligned) || (state_q == S_WAIT && expired)) begin
            tag_v_q    <= 1'b0;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_inst = NOP_INST;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            inst_q  <= NOP_INST;
            cnt_q   <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end
    // pc is captured on every edge that enters REQ, so the address is purely registered.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                addr_d  = pc_i;
            end
            S_REQ: begin
                if (misaligned) begin
                    inst_d  = NOP_INST;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (hit) begin
                    inst_d  = hit_inst;
                    state_d = S_DONE;
                end else if (imem_gnt_i) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    inst_d  = imem_rdata_i;
                    state_d = S_DONE;
                end else if (expired) begin
                    inst_d  = NOP_INST;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = cnt_q + 32'd1;
                addr_d  = pc_i;
                state_d = S_REQ;
            end
        endcase
    end
    always_comb begin
        imem_req_o   = state_q == S_REQ && !misaligned && !hit;
        imem_addr_o  = addr_q;
        inst_valid_o = state_q == S_DONE;
        inst_o       = state_q == S_DONE ? inst_q : NOP_INST;
        fetch_err_o  = err_q;
        fetch_cnt_o  = cnt_q;
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed fetches with a scoreboard queue popped by an inst_valid monitor.
module tb_inst_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        fetch_err_o;
    logic [31:0] fetch_cnt_o;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
        logic [31:0] cnt;
    } exp_t;
    exp_t q[$];
    int tests = 0;
    int fails = 0;
    logic [31:0] exp_cnt = 0;

    inst_fetch_unit #(.TIMEOUT(16), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .fetch_err_o(fetch_err_o), .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every inst_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && inst_valid_o) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got inst %h expected no pulse", inst_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_inst", inst_o, e.inst);
                check("sb_err", {31'd0, fetch_err_o}, {31'd0, e.err});
                check("sb_cnt", fetch_cnt_o, e.cnt);
            end
        end else begin
            check("nop_idle", inst_o, NOP);
        end
    end

    // Starts at a negedge inside the first REQ cycle; ends at a negedge inside the next REQ.
    // g: ungranted REQ cycles; rv: WAIT cycles before rvalid (-1 = never); stray: late rvalid at n==1.
    task automatic fetch(input logic [31:0] addr, input bit exp_req, input int g, input int rv,
                         input logic [31:0] rdata, input logic [31:0] exp_inst, input bit exp_err,
                         input int exp_lat, input bit stray, input logic [31:0] next_pc);
        int n = 0;
        q.push_back('{inst: exp_inst, err: exp_err, cnt: exp_cnt});
        exp_cnt++;
        while (!inst_valid_o && n < 60) begin
            check("req", {31'd0, imem_req_o}, {31'd0, exp_req && n <= g});
            if (imem_req_o) check("addr", imem_addr_o, addr);
            imem_gnt_i    = exp_req && n == g;
            imem_rvalid_i = (exp_req && rv >= 0 && n == g + 1 + rv) || (stray && n == 1);
            imem_rdata_i  = imem_rvalid_i ? (stray && n == 1 ? 32'hBAD0_BAD0 : rdata) : 32'hDEAD_BEEF;
            @(negedge clk);
            n++;
        end
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        check("latency", n, exp_lat);
        check("req_in_done", {31'd0, imem_req_o}, 32'd0);
        pc_i = next_pc;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        pc_i = 32'h0;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_addr", imem_addr_o, 32'd0);
        check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("rst_inst", inst_o, NOP);
        check("rst_err", {31'd0, fetch_err_o}, 32'd0);
        check("rst_cnt", fetch_cnt_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        // basic 3-cycle fetch
        fetch(32'h0, 1, 0, 0, 32'h0050_0093, 32'h0050_0093, 0, 2, 0, 32'h4);
        check("cnt_after_first", fetch_cnt_o, 32'd1);
        // grant held off 5 cycles
        fetch(32'h4, 1, 5, 1, 32'h00A0_0113, 32'h00A0_0113, 0, 8, 0, 32'h8);
        // rvalid never arrives: 16 WAIT cycles then NOP with error
        fetch(32'h8, 1, 0, -1, 32'h0, NOP, 1, 17, 0, 32'hC);
        check("err_after_timeout", {31'd0, fetch_err_o}, 32'd1);
        // late rvalid lands in REQ and must be ignored; error stays sticky
        fetch(32'hC, 1, 2, 0, 32'h0020_81B3, 32'h0020_81B3, 1, 4, 1, 32'h6);
        // misaligned pc: no request, NOP one cycle later
        fetch(32'h6, 0, 0, 0, 32'h0, NOP, 1, 1, 0, 32'h10);
        check("cnt_after_misalign", fetch_cnt_o, 32'd5);
        // same pc twice
        fetch(32'h10, 1, 0, 0, 32'h0010_0193, 32'h0010_0193, 1, 2, 0, 32'h10);
`ifdef FETCH_REUSE_EN
        fetch(32'h10, 0, 0, 0, 32'h0, 32'h0010_0193, 1, 1, 0, 32'h14);
`else
        fetch(32'h10, 1, 0, 0, 32'h0010_0193, 32'h0010_0193, 1, 2, 0, 32'h14);
`endif
        // reset asserted while waiting for data
        check("pre_rst_addr", imem_addr_o, 32'h14);
        imem_gnt_i = 1'b1;
        @(negedge clk);
        imem_gnt_i = 1'b0;
        check("wait_req_low", {31'd0, imem_req_o}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", {31'd0, imem_req_o}, 32'd0);
        check("async_rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("async_rst_cnt", fetch_cnt_o, 32'd0);
        check("async_rst_err", {31'd0, fetch_err_o}, 32'd0);
        check("async_rst_addr", imem_addr_o, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        imem_rvalid_i = 1'b0;
        check("rst_hold_valid", {31'd0, inst_valid_o}, 32'd0);
        exp_cnt = 0;
        pc_i = 32'h20;
        rst_n = 1'b1;
        @(negedge clk);
        fetch(32'h20, 1, 0, 0, 32'h0000_0093, 32'h0000_0093, 0, 2, 0, 32'h24);
        check("cnt_after_reset", fetch_cnt_o, 32'd1);
        @(negedge clk);
        check("sb_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
